qpsk_symbol_packer: RTL and testbench
=====================================

Name: qpsk_symbol_packer

Overview:
- Sits directly downstream of the QPSK carrier/bit-sync stage, inside the same RFNoC block, on the 32-bit AXI-stream of one {I,Q} sample per symbol.
- Removes the Costas phase ambiguity with a programmable 90° rotation.
- Hard-slices each symbol to a dibit and packs 16 dibits MSB-first into 32-bit words.
- Emits packets of PKT_WORDS words toward the axi_wrapper; a partial word is flushed on input tlast.

Parameters:
- PKT_WORDS, 64, output words per packet (>=1); o_tlast on the last word.
- IQ_W, 16, width of each I and Q component in i_tdata.

Ports:
- ce_clk  in  1  block clock.
- ce_rst  in  1  reset: asynchronous, active-high, clock ce_clk.
- rot_sel  in  2  phase rotation before slicing: 0=0°, 1=90°, 2=180°, 3=270°.
- i_tdata  in  2*IQ_W  symbol, {I[31:16], Q[15:0]}, two's complement.
- i_tvalid  in  1  input valid.
- i_tlast  in  1  end of burst; forces flush of the current word.
- i_tready  out  1  input ready.
- o_tdata  out  32  packed dibits; symbol 0 in [31:30].
- o_tuser  out  5  valid symbols in the word, 1..16.
- o_tlast  out  1  last word of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- sym_count  out  32  accepted-symbol counter; wraps at 2^32.

Behaviour:
- Reset: o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0, sym_count=0, symbol index=0, word index=0. i_tready=0 while ce_rst is high. Asserting reset mid-word discards the partial word.
- Slicing: si=I[IQ_W-1], sq=Q[IQ_W-1]. Zero is positive.
- Rotation is applied to the hard bits as (b1,b0):
  - rot_sel 0: (si,sq)
  - rot_sel 1: (~sq,si)
  - rot_sel 2: (~si,~sq)
  - rot_sel 3: (sq,~si)
- rot_sel is sampled on each accepted symbol; a change affects only subsequent symbols.
- Handshake:
  - A symbol is accepted when i_tvalid & i_tready.
  - i_tready = ~ce_rst & (~o_tvalid | o_tready), a single-entry output register.
  - o_tdata, o_tuser and o_tlast are held stable while o_tvalid & ~o_tready.
- Packing:
  - The accepted dibit is written to bits [31-2k : 30-2k] of the shift word, where k is the symbol index 0..15.
  - The word is committed to the output register when k==15 or i_tlast=1 on the accepted symbol.
  - Latency: o_tvalid rises the cycle after the committing symbol is accepted.
- Partial word: unused low bits are 0, o_tuser=k+1, and o_tlast=1 regardless of word index.
- Full word: o_tuser=16.
- Word index counts committed words 0..PKT_WORDS-1.
  - o_tlast=1 when the index is PKT_WORDS-1 or on a flush.
  - The index returns to 0 after any tlast word.
  - PKT_WORDS=1 gives tlast on every word.
- The symbol index returns to 0 after every commit.
- i_tlast on symbol 15 is a normal full word with tlast; there is no extra empty word.
- Simultaneous output drain (o_tvalid & o_tready) and a new commit in the same cycle: the new word loads and o_tvalid stays 1.
- sym_count increments on every accepted symbol.

Decomposition:
- Package qpsk_pkg:
  - SYM_PER_WORD=16
  - DIBIT_W=2
  - rotation encodings ROT_0/ROT_90/ROT_180/ROT_270
  - word-count and symbol-index widths derived from parameters
- Sub-module qpsk_slicer: purely combinational rotate+slice, 2*IQ_W in, 2-bit dibit out. The packer instantiates it once.

Test Plan:
- rot_sel=0, 16 symbols I=+1000, Q=-1000 -> one word o_tdata=0x55555555, o_tuser=16, o_tlast=0 (PKT_WORDS=64).
- Input I=+5, Q=-5 for 16 symbols:
  - rot_sel=1 -> 0x00000000
  - rot_sel=2 -> 0xAAAAAAAA
  - rot_sel=3 -> 0xFFFFFFFF
  - I=0, Q=0, rot_sel=0 -> 0x00000000
- PKT_WORDS=4, 64 symbols continuous, o_tready=1 -> 4 words, o_tlast only on the 4th; the next packet starts at word index 0.
- Three symbols with dibits 11, 00, 11, i_tlast on the third -> o_tdata=0xCC000000, o_tuser=3, o_tlast=1. The next 16 symbols form a fresh full word.
- Hold o_tready=0 for 10 cycles with o_tvalid=1 -> i_tready=0 and o_tdata stable throughout. After release, the output stream equals the reference model with no loss or duplication; sym_count equals the accepted count.
- Assert ce_rst after 7 symbols of a word -> all outputs 0 and sym_count=0. After release, 16 symbols produce a word whose first symbol is in [31:30].

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared constants for the QPSK hard-slice / dibit packing path.
package qpsk_pkg;

    localparam int unsigned SYM_PER_WORD = 16;
    localparam int unsigned DIBIT_W      = 2;
    localparam int unsigned WORD_W       = SYM_PER_WORD * DIBIT_W;
    localparam int unsigned SYM_IDX_W    = $clog2(SYM_PER_WORD);
    localparam int unsigned USER_W       = SYM_IDX_W + 1;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    // Counter width for a 0..n-1 index, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qpsk_slicer.sv
// Combinational hard slicer: sign bits of I/Q, rotated in 90 degree steps, to one dibit.
module qpsk_slicer
    import qpsk_pkg::*;
#(
    parameter int unsigned IQ_W = 16
) (
    input  logic [2*IQ_W-1:0]  iq_i,
    input  logic [1:0]         rot_i,
    output logic [DIBIT_W-1:0] dibit_o
);

    logic si;
    logic sq;
    logic unused_mag;

    // Zero slices as positive: only the sign bit matters.
    assign si = iq_i[2*IQ_W-1];
    assign sq = iq_i[IQ_W-1];
    assign unused_mag = ^{iq_i[2*IQ_W-2:IQ_W], iq_i[IQ_W-2:0]};

    always_comb begin
        dibit_o = {si, sq};
        unique case (rot_i)
            ROT_0:   dibit_o = {si, sq};
            ROT_90:  dibit_o = {~sq, si};
            ROT_180: dibit_o = {~si, ~sq};
            ROT_270: dibit_o = {sq, ~si};
        endcase
    end

endmodule

// File: rtl/qpsk_symbol_packer.sv
// Packs 16 sliced QPSK dibits MSB-first per 32-bit word and frames words into packets.
module qpsk_symbol_packer
    import qpsk_pkg::*;
#(
    parameter int unsigned PKT_WORDS = 64,
    parameter int unsigned IQ_W      = 16
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic [1:0]        rot_sel,
    input  logic [2*IQ_W-1:0] i_tdata,
    input  logic              i_tvalid,
    input  logic              i_tlast,
    output logic              i_tready,
    output logic [31:0]       o_tdata,
    output logic [4:0]        o_tuser,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [31:0]       sym_count
);

    localparam int unsigned WCNT_W = cnt_width(PKT_WORDS);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_WORDS - 1);
    localparam logic [SYM_IDX_W-1:0] LAST_SYM = SYM_IDX_W'(SYM_PER_WORD - 1);

    logic [DIBIT_W-1:0]   dibit;
    logic                 accept;
    logic                 commit;
    logic                 word_last;
    logic [SYM_IDX_W:0]   bit_lo;
    logic [WORD_W-1:0]    word_next;

    logic [WORD_W-1:0]    shift_q,   shift_d;
    logic [SYM_IDX_W-1:0] sym_idx_q, sym_idx_d;
    logic [WCNT_W-1:0]    wcnt_q,    wcnt_d;
    logic [WORD_W-1:0]    data_q,    data_d;
    logic [USER_W-1:0]    user_q,    user_d;
    logic                 last_q,    last_d;
    logic                 valid_q,   valid_d;
    logic [31:0]          cnt_q,     cnt_d;

    qpsk_slicer #(
        .IQ_W (IQ_W)
    ) u_slicer (
        .iq_i    (i_tdata),
        .rot_i   (rot_sel),
        .dibit_o (dibit)
    );

    assign i_tready  = ~ce_rst & (~valid_q | o_tready);
    assign accept    = i_tvalid & i_tready;
    assign commit    = accept & ((sym_idx_q == LAST_SYM) | i_tlast);
    assign word_last = i_tlast | (wcnt_q == LAST_WORD);
    assign bit_lo    = (SYM_IDX_W+1)'(WORD_W - DIBIT_W) - {sym_idx_q, 1'b0};

    // Low bits of shift_q are always clear, so a flushed partial word is zero-padded.
    always_comb begin
        word_next = shift_q;
        word_next[bit_lo +: DIBIT_W] = dibit;
    end

    always_comb begin
        shift_d   = shift_q;
        sym_idx_d = sym_idx_q;
        wcnt_d    = wcnt_q;
        data_d    = data_q;
        user_d    = user_q;
        last_d    = last_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        if (valid_q && o_tready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            cnt_d = cnt_q + 32'd1;
            if (commit) begin
                shift_d   = '0;
                sym_idx_d = '0;
                data_d    = word_next;
                user_d    = {1'b0, sym_idx_q} + USER_W'(1);
                last_d    = word_last;
                valid_d   = 1'b1;
                wcnt_d    = word_last ? '0 : wcnt_q + WCNT_W'(1);
            end else begin
                shift_d   = word_next;
                sym_idx_d = sym_idx_q + SYM_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            shift_q   <= '0;
            sym_idx_q <= '0;
            wcnt_q    <= '0;
            data_q    <= '0;
            user_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            sym_idx_q <= sym_idx_d;
            wcnt_q    <= wcnt_d;
            data_q    <= data_d;
            user_q    <= user_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_tdata   = data_q;
    assign o_tuser   = user_q;
    assign o_tlast   = last_q;
    assign o_tvalid  = valid_q;
    assign sym_count = cnt_q;

endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Scoreboard bench for qpsk_symbol_packer: directed cases plus randomized traffic with backpressure.
module tb_qpsk_symbol_packer;

    localparam int unsigned PKT_WORDS = 4;
    localparam int unsigned IQ_W      = 16;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic [1:0]  rot_sel = 2'd0;
    logic [31:0] i_tdata = '0;
    logic        i_tvalid = 1'b0;
    logic        i_tlast = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic [4:0]  o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [31:0] sym_count;

    qpsk_symbol_packer #(
        .PKT_WORDS (PKT_WORDS),
        .IQ_W      (IQ_W)
    ) dut (
        .ce_clk    (ce_clk),
        .ce_rst    (ce_rst),
        .rot_sel   (rot_sel),
        .i_tdata   (i_tdata),
        .i_tvalid  (i_tvalid),
        .i_tlast   (i_tlast),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tuser   (o_tuser),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .sym_count (sym_count)
    );

    always #5 ce_clk = ~ce_clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  user;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [1:0]  cur_q[$];
    logic        tlast_hist[$];
    int          widx = 0;
    int unsigned sym_exp = 0;
    int          tests = 0;
    int          fails = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_user = '0;
    logic        last_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference slicer: sign decision then the rotation table on the hard bits.
    function automatic logic [1:0] ref_dibit(input logic [15:0] i, input logic [15:0] q,
                                             input logic [1:0] r);
        logic si;
        logic sq;
        si = ($signed(i) < 0);
        sq = ($signed(q) < 0);
        case (r)
            2'd0:    return {si, sq};
            2'd1:    return {~sq, si};
            2'd2:    return {~si, ~sq};
            default: return {sq, ~si};
        endcase
    endfunction

    task automatic model_accept(input logic [15:0] i, input logic [15:0] q, input logic [1:0] r,
                                input logic last);
        word_t w;
        cur_q.push_back(ref_dibit(i, q, r));
        sym_exp++;
        if (cur_q.size() == 16 || last) begin
            w.data = 0;
            foreach (cur_q[k]) w.data = w.data + 32'(cur_q[k]) * (32'd1 << (30 - 2 * k));
            w.user = 5'(cur_q.size());
            w.last = last || (widx == PKT_WORDS - 1);
            widx   = w.last ? 0 : widx + 1;
            exp_q.push_back(w);
            cur_q.delete();
        end
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q, input logic [1:0] r,
                        input logic last);
        int n;
        @(posedge ce_clk);
        #1;
        i_tdata  = {i, q};
        rot_sel  = r;
        i_tlast  = last;
        i_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge ce_clk);
            if (i_tready) begin
                model_accept(i, q, r, last);
                break;
            end
            n++;
            if (n >= 300) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: got i_tready=0 for %0d cycles, expected acceptance", n);
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge ce_clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [15:0] i, input logic [15:0] q,
                          input logic [1:0] r);
        for (int k = 0; k < n; k++) send(i, q, r, 1'b0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || o_tvalid) begin
            @(negedge ce_clk);
            n++;
            if (n >= 500) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
                break;
            end
        end
    endtask

    // Monitor: a transfer visible at the negedge completes on the next posedge.
    initial begin
        word_t w;
        forever begin
            @(negedge ce_clk);
            if (!ce_rst && o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%08h, expected no word", o_tdata);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", 64'(o_tdata), 64'(w.data));
                    check("word_user", 64'(o_tuser), 64'(w.user));
                    check("word_last", 64'(o_tlast), 64'(w.last));
                end
                last_data = o_tdata;
                last_user = o_tuser;
                last_last = o_tlast;
                tlast_hist.push_back(o_tlast);
            end
        end
    end

    initial begin
        forever begin
            @(posedge ce_clk);
            #1;
            if (rand_ready) o_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [31:0] held;
        logic [15:0] ri;
        logic [15:0] rq;

        repeat (3) @(negedge ce_clk);
        check("rst_tready", 64'(i_tready), 64'd0);
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tdata", 64'(o_tdata), 64'd0);
        check("rst_symcnt", 64'(sym_count), 64'd0);
        ce_rst = 1'b0;

        // Fixed-symbol words across all four rotations and the zero point.
        send_n(16, 16'sd1000, -16'sd1000, 2'd0);
        idle();
        wait_drain();
        check("rot0_word", 64'(last_data), 64'h55555555);
        check("rot0_user", 64'(last_user), 64'd16);
        check("rot0_last", 64'(last_last), 64'd0);
        send_n(16, 16'sd5, -16'sd5, 2'd1);
        idle();
        wait_drain();
        check("rot90_word", 64'(last_data), 64'h00000000);
        send_n(16, 16'sd5, -16'sd5, 2'd2);
        idle();
        wait_drain();
        check("rot180_word", 64'(last_data), 64'hAAAAAAAA);
        send_n(16, 16'sd5, -16'sd5, 2'd3);
        idle();
        wait_drain();
        check("rot270_word", 64'(last_data), 64'hFFFFFFFF);
        send_n(16, 16'd0, 16'd0, 2'd0);
        idle();
        wait_drain();
        check("zero_word", 64'(last_data), 64'h00000000);

        // Flush of a three-symbol partial word.
        send(-16'sd7, -16'sd7, 2'd0, 1'b0);
        send(16'sd7, 16'sd7, 2'd0, 1'b0);
        send(-16'sd7, -16'sd7, 2'd0, 1'b1);
        idle();
        wait_drain();
        check("flush_word", 64'(last_data), 64'hCC000000);
        check("flush_user", 64'(last_user), 64'd3);
        check("flush_last", 64'(last_last), 64'd1);

        // One full packet of continuous symbols, then the first word of the next.
        tlast_hist.delete();
        for (int k = 0; k < 64; k++) begin
            send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
        end
        idle();
        wait_drain();
        check("pkt_words", 64'(tlast_hist.size()), 64'd4);
        for (int k = 0; k < 4 && k < tlast_hist.size(); k++) begin
            check("pkt_tlast", 64'(tlast_hist[k]), (k == 3) ? 64'd1 : 64'd0);
        end
        send_n(16, -16'sd3, 16'sd3, 2'd0);
        idle();
        wait_drain();
        check("next_word", 64'(last_data), 64'hAAAAAAAA);
        check("next_user", 64'(last_user), 64'd16);
        check("next_last", 64'(last_last), 64'd0);
        check("symcnt_a", 64'(sym_count), 64'(sym_exp));

        // Output stall: the held word must not move and input must be refused.
        @(posedge ce_clk);
        #1;
        o_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
                end
                idle();
            end
            begin
                @(negedge ce_clk);
                held = o_tdata;
                for (int k = 0; k < 10; k++) begin
                    check("stall_valid", 64'(o_tvalid), 64'd1);
                    check("stall_ready", 64'(i_tready), 64'd0);
                    check("stall_data", 64'(o_tdata), 64'(held));
                    @(negedge ce_clk);
                end
                @(posedge ce_clk);
                #1;
                o_tready = 1'b1;
            end
        join
        wait_drain();

        // Randomized traffic with random backpressure and bursts.
        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            ri = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            rq = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            send(ri, rq, 2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0));
            if ($urandom_range(0, 9) == 0) idle();
        end
        idle();
        rand_ready = 1'b0;
        @(posedge ce_clk);
        #2;
        o_tready = 1'b1;
        wait_drain();
        check("symcnt_b", 64'(sym_count), 64'(sym_exp));

        // Reset in the middle of a word discards it.
        send_n(7, 16'sd9, 16'sd9, 2'd0);
        idle();
        @(negedge ce_clk);
        ce_rst = 1'b1;
        #1;
        check("mrst_tvalid", 64'(o_tvalid), 64'd0);
        check("mrst_tdata", 64'(o_tdata), 64'd0);
        check("mrst_tuser", 64'(o_tuser), 64'd0);
        check("mrst_tlast", 64'(o_tlast), 64'd0);
        check("mrst_symcnt", 64'(sym_count), 64'd0);
        check("mrst_tready", 64'(i_tready), 64'd0);
        cur_q.delete();
        exp_q.delete();
        widx    = 0;
        sym_exp = 0;
        @(negedge ce_clk);
        ce_rst = 1'b0;
        send(-16'sd9, 16'sd9, 2'd0, 1'b0);
        send_n(15, 16'sd9, 16'sd9, 2'd0);
        idle();
        wait_drain();
        check("post_rst_word", 64'(last_data), 64'h80000000);
        check("post_rst_last", 64'(last_last), 64'd0);
        check("post_rst_cnt", 64'(sym_count), 64'd16);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
